retire_unit: RTL and testbench

RETIRE_UNIT -- requirements
Module: retire_unit

---
 rtl/retire_unit.sv | 122 ++++++++++++
 tb/tb_retire_unit.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/retire_unit.sv
// In-order retirement for a reorder queue: retires up to SS completed entries per cycle,
// updates the retirement RAT and free list, and raises a timed flush on a mispredict.
module retire_unit #(
    parameter int SS           = 2,
    parameter int DEPTH        = 16,
    parameter int PREG_W       = 6,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [$clog2(DEPTH):0]        q_count,
    input  logic [$clog2(DEPTH)-1:0]      q_tail,
    output logic [SS*$clog2(DEPTH)-1:0]   sel_idx,
    input  logic [SS-1:0]                 e_done,
    input  logic [SS-1:0]                 e_we,
    input  logic [SS*5-1:0]               e_rd_arch,
    input  logic [SS*PREG_W-1:0]          e_rd_phys,
    input  logic [SS*PREG_W-1:0]          e_old_phys,
    input  logic [SS-1:0]                 e_mispred,
    input  logic [SS*32-1:0]              e_target,
    output logic                          pop,
    output logic [$clog2(SS):0]           pop_count,
    output logic [SS-1:0]                 rrf_we,
    output logic [SS*5-1:0]               rrf_arch,
    output logic [SS*PREG_W-1:0]          rrf_phys,
    output logic [SS-1:0]                 fl_push,
    output logic [SS*PREG_W-1:0]          fl_phys,
    output logic                          flush,
    output logic [31:0]                   redirect_pc,
    output logic [63:0]                   retired_total
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(SS) + 1;
    localparam int FC_W  = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t            state;
    logic [FC_W-1:0]   fcnt;
    logic [SS-1:0]     ret;
    logic [CNT_W-1:0]  cnt;
    logic              stop;
    logic              mis_hit;
    logic [31:0]       mis_pc;

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < SS; i++)
            sel_idx[i*IDX_W +: IDX_W] = q_tail + IDX_W'(i);
    end

    // Walk slots oldest-first; out-of-range slots are rejected before their
    // (possibly unknown) inputs are consulted, and a mispredict ends the group.
    always_comb begin
        ret     = '0;
        cnt     = '0;
        stop    = 1'b0;
        mis_hit = 1'b0;
        mis_pc  = '0;
        if (!rst && state == RUN) begin
            for (int i = 0; i < SS; i++) begin
                if (!stop && ((IDX_W+1)'(i) < q_count) && e_done[i]) begin
                    ret[i] = 1'b1;
                    cnt    = cnt + CNT_W'(1);
                    if (e_mispred[i]) begin
                        stop    = 1'b1;
                        mis_hit = 1'b1;
                        mis_pc  = e_target[i*32 +: 32];
                    end
                end else begin
                    stop = 1'b1;
                end
            end
        end
    end

    assign pop       = (cnt != '0);
    assign pop_count = cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            fcnt          <= '0;
            rrf_we        <= '0;
            fl_push       <= '0;
            flush         <= 1'b0;
            redirect_pc   <= '0;
            retired_total <= '0;
        end else begin
            rrf_we        <= ret & e_we;
            fl_push       <= ret & e_we;
            flush         <= mis_hit;
            retired_total <= retired_total + 64'(cnt);
            if (mis_hit)
                redirect_pc <= mis_pc;
            case (state)
                RUN: begin
                    if (mis_hit) begin
                        state <= FLUSH;
                        fcnt  <= FC_W'(FLUSH_CYCLES - 1);
                    end
                end
                FLUSH: begin
                    if (fcnt == '0)
                        state <= RUN;
                    else
                        fcnt <= fcnt - FC_W'(1);
                end
                default: state <= RUN;
            endcase
        end
    end

    // Payload fields are not reset; they are zeroed every cycle for non-retired slots.
    always_ff @(posedge clk) begin
        for (int i = 0; i < SS; i++) begin
            rrf_arch[i*5 +: 5]        <= ret[i] ? e_rd_arch[i*5 +: 5] : 5'd0;
            rrf_phys[i*PREG_W +: PREG_W] <= ret[i] ? e_rd_phys[i*PREG_W +: PREG_W] : '0;
            fl_phys[i*PREG_W +: PREG_W]  <= ret[i] ? e_old_phys[i*PREG_W +: PREG_W] : '0;
        end
    end
endmodule

// File: tb/tb_retire_unit.sv
// Directed bench for retire_unit with default parameters (SS=2, DEPTH=16, PREG_W=6, FLUSH_CYCLES=2).
module tb_retire_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  q_count;
    logic [3:0]  q_tail;
    logic [7:0]  sel_idx;
    logic [1:0]  e_done, e_we, e_mispred;
    logic [9:0]  e_rd_arch;
    logic [11:0] e_rd_phys, e_old_phys;
    logic [63:0] e_target;
    logic        pop;
    logic [1:0]  pop_count;
    logic [1:0]  rrf_we, fl_push;
    logic [9:0]  rrf_arch;
    logic [11:0] rrf_phys, fl_phys;
    logic        flush;
    logic [31:0] redirect_pc;
    logic [63:0] retired_total;

    int total = 0;
    int bad   = 0;

    retire_unit dut (
        .clk(clk), .rst(rst), .q_count(q_count), .q_tail(q_tail), .sel_idx(sel_idx),
        .e_done(e_done), .e_we(e_we), .e_rd_arch(e_rd_arch), .e_rd_phys(e_rd_phys),
        .e_old_phys(e_old_phys), .e_mispred(e_mispred), .e_target(e_target),
        .pop(pop), .pop_count(pop_count), .rrf_we(rrf_we), .rrf_arch(rrf_arch),
        .rrf_phys(rrf_phys), .fl_push(fl_push), .fl_phys(fl_phys), .flush(flush),
        .redirect_pc(redirect_pc), .retired_total(retired_total)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        q_count = 5'd0; e_done = 2'b00; e_we = 2'b00; e_mispred = 2'b00;
    endtask

    initial begin
        rst = 1'b1; q_tail = 4'd0; idle();
        e_rd_arch = 10'd0; e_rd_phys = 12'd0; e_old_phys = 12'd0; e_target = 64'd0;
        tick(); tick();
        q_count = 5'd3; e_done = 2'b11; #1;
        chk("rst_pop", pop, 0);
        chk("rst_rrf_we", rrf_we, 0);
        chk("rst_fl_push", fl_push, 0);
        chk("rst_flush", flush, 0);
        chk("rst_redirect", redirect_pc, 0);
        chk("rst_total", retired_total, 0);

        // two completed entries retire together
        rst = 1'b0; idle();
        q_count = 5'd3; e_done = 2'b11; e_we = 2'b11;
        e_rd_arch = {5'd7, 5'd3}; e_rd_phys = {6'd11, 6'd10}; e_old_phys = {6'd21, 6'd20};
        #1;
        chk("basic_pop", pop, 1);
        chk("basic_cnt", pop_count, 2);
        chk("basic_sel", sel_idx, 8'h10);
        tick(); idle(); #1;
        chk("basic_rrf_we", rrf_we, 2'b11);
        chk("basic_fl_push", fl_push, 2'b11);
        chk("basic_arch", rrf_arch, {5'd7, 5'd3});
        chk("basic_phys", rrf_phys, {6'd11, 6'd10});
        chk("basic_old", fl_phys, {6'd21, 6'd20});
        chk("basic_total", retired_total, 2);

        // partial write-enable
        q_count = 5'd2; e_done = 2'b11; e_we = 2'b10; #1;
        chk("we_cnt", pop_count, 2);
        tick(); idle(); #1;
        chk("we_rrf_we", rrf_we, 2'b10);
        chk("we_fl_push", fl_push, 2'b10);
        chk("we_total", retired_total, 4);

        // oldest not done blocks everything
        q_count = 5'd3; e_done = 2'b10; e_we = 2'b11; #1;
        chk("blk_pop", pop, 0);
        chk("blk_cnt", pop_count, 0);
        tick(); idle(); #1;
        chk("blk_rrf_we", rrf_we, 0);
        chk("blk_fl_push", fl_push, 0);
        chk("blk_total", retired_total, 4);

        // slot beyond q_count ignored even with unknown inputs
        q_count = 5'd1; e_done = 2'bx1; e_we = 2'bx1; e_mispred = 2'bx0; #1;
        chk("qc_cnt", pop_count, 1);
        tick(); idle(); #1;
        chk("qc_rrf_we", rrf_we, 2'b01);
        chk("qc_total", retired_total, 5);

        // queue index wrap
        q_tail = 4'd15; q_count = 5'd2; e_done = 2'b11; e_we = 2'b11; #1;
        chk("wrap_sel", sel_idx, {4'd0, 4'd15});
        chk("wrap_cnt", pop_count, 2);
        tick(); idle(); #1;
        chk("wrap_rrf_we", rrf_we, 2'b11);
        chk("wrap_total", retired_total, 7);

        // mispredict in slot 0 truncates the group and flushes
        q_tail = 4'd0; q_count = 5'd3; e_done = 2'b11; e_we = 2'b01; e_mispred = 2'b01;
        e_target = {32'h12345678, 32'h80001000}; #1;
        chk("mp_cnt", pop_count, 1);
        tick(); e_mispred = 2'b00; e_we = 2'b11; #1;
        chk("mp_flush", flush, 1);
        chk("mp_redirect", redirect_pc, 32'h80001000);
        chk("mp_rrf_we", rrf_we, 2'b01);
        chk("mp_total", retired_total, 8);
        chk("mp_quiet0", pop, 0);
        tick();
        chk("mp_flush_pulse", flush, 0);
        chk("mp_quiet1", pop, 0);
        chk("mp_total_hold", retired_total, 8);
        tick();
        chk("mp_run_pop", pop, 1);
        chk("mp_run_cnt", pop_count, 2);
        idle(); #1;
        chk("empty_pop", pop, 0);

        // reset during the first flush cycle
        q_count = 5'd2; e_done = 2'b11; e_mispred = 2'b01; e_target = {32'h0, 32'hdead0000}; #1;
        tick(); idle(); #1;
        chk("rf_flush", flush, 1);
        rst = 1'b1;
        tick();
        chk("rf_flush_clr", flush, 0);
        chk("rf_total_clr", retired_total, 0);
        chk("rf_redirect_clr", redirect_pc, 0);
        rst = 1'b0; q_count = 5'd2; e_done = 2'b11; e_we = 2'b11; #1;
        chk("rf_run_cnt", pop_count, 2);
        tick(); idle(); #1;
        chk("rf_run_total", retired_total, 2);
        chk("rf_no_flush", flush, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1);
    end
endmodule
